// File: rtl/serial_adder_pkg.sv
// Shared FSM encoding and default operand width for the bit-serial adder.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// Gate-level one-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ab_x;
  logic ab_a;
  logic cx_a;

  xor g_x1 (ab_x, a, b);
  xor g_x2 (sum, ab_x, cin);
  and g_a1 (ab_a, a, b);
  and g_a2 (cx_a, ab_x, cin);
  or  g_o1 (cout, ab_a, cx_a);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one bit pair per clock, LSB first, through a single full_adder.
// Define SERIAL_ADDER_OVF_EN to add a registered two's-complement overflow output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state;
  state_t next;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next;
  end

  always_comb begin
    next = state;
    busy = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: if (start) next = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) next = DONE;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Result registers only move on the final RUN edge so downstream logic sees a stable value.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          s_sh  <= {fa_sum, s_sh[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= fa_cout;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            sum  <= {fa_sum, s_sh[WIDTH-1:1]};
            cout <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            ovf  <= carry ^ fa_cout;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder with an arithmetic reference model checked every cycle.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;
  bit chkEn  = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: cycles remaining in the current operation and the arithmetic answer.
  int         rem = 0;
  logic [W:0] pend;
  logic       pendOvf;
  logic [W-1:0] expSum;
  logic       expCout;
  logic       expOvf;

  function automatic logic signedOvf(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    longint s;
    s = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    return (s > (longint'(1) << (W - 1)) - 1) || (s < -(longint'(1) << (W - 1)));
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      rem     <= 0;
      expSum  <= '0;
      expCout <= 1'b0;
      expOvf  <= 1'b0;
    end else if (rem == 0) begin
      if (start) begin
        rem     <= W + 1;
        pend    <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        pendOvf <= signedOvf(a, b, cin);
      end
    end else begin
      rem <= rem - 1;
      if (rem == 2) begin
        {expCout, expSum} <= pend;
        expOvf            <= pendOvf;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("cyc_busy", 32'(busy), 32'(rem != 0));
      checkOutput("cyc_done", 32'(done), 32'(rem == 1));
      checkOutput("cyc_sum",  32'(sum),  32'(expSum));
      checkOutput("cyc_cout", 32'(cout), 32'(expCout));
`ifdef SERIAL_ADDER_OVF_EN
      checkOutput("cyc_ovf",  32'(ovf),  32'(expOvf));
`endif
    end
  end

  task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic);
    @(negedge clk);
    start = 1'b1;
    a     = ia;
    b     = ib;
    cin   = ic;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input string name, output int n);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout: got done=%0b after %0d cycles expected done=1", name, done, n);
    end
  endtask

  int n;
  int pulses;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_sum",  32'(sum),  32'd0);
    checkOutput("rst_cout", 32'(cout), 32'd0);
    rst   = 1'b0;
    chkEn = 1'b1;

    applyStimulus(8'h0F, 8'h01, 1'b0);
    checkOutput("t1_busy_first", 32'(busy), 32'd1);
    waitDone("t1", n);
    checkOutput("t1_latency", 32'(n), 32'd9);
    checkOutput("t1_sum",  32'(sum),  32'h10);
    checkOutput("t1_cout", 32'(cout), 32'd0);

    applyStimulus(8'hFF, 8'h01, 1'b0);
    waitDone("t2", n);
    checkOutput("t2_sum",  32'(sum),  32'h00);
    checkOutput("t2_cout", 32'(cout), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("t2_ovf",  32'(ovf),  32'd0);
`endif

    applyStimulus(8'h7F, 8'h01, 1'b0);
    waitDone("t3", n);
    checkOutput("t3_sum",  32'(sum),  32'h80);
    checkOutput("t3_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("t3_ovf",  32'(ovf),  32'd1);
`endif

    // Start held high across DONE: the next operation is taken in the following IDLE cycle.
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    waitDone("t4a", n);
    checkOutput("t4a_sum",  32'(sum),  32'hFF);
    checkOutput("t4a_cout", 32'(cout), 32'd1);
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h02;
    cin   = 1'b0;
    @(negedge clk);
    checkOutput("t4_gap_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("t4_reaccept_busy", 32'(busy), 32'd1);
    start = 1'b0;
    waitDone("t4b", n);
    checkOutput("t4b_latency", 32'(n), 32'd9);
    checkOutput("t4b_sum",  32'(sum),  32'h03);
    checkOutput("t4b_cout", 32'(cout), 32'd0);

    applyStimulus(8'h10, 8'h20, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h55;
    @(negedge clk);
    start = 1'b0;
    a     = '0;
    b     = '0;
    waitDone("t5", n);
    checkOutput("t5_sum",  32'(sum),  32'h30);
    checkOutput("t5_cout", 32'(cout), 32'd0);

    applyStimulus(8'h55, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_done", 32'(done), 32'd0);
    checkOutput("t6_rst_sum",  32'(sum),  32'd0);
    checkOutput("t6_rst_cout", 32'(cout), 32'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checkOutput("t6_no_done", 32'(pulses), 32'd0);
    applyStimulus(8'h03, 8'h04, 1'b0);
    waitDone("t6", n);
    checkOutput("t6_latency", 32'(n), 32'd9);
    checkOutput("t6_sum",  32'(sum),  32'h07);
    checkOutput("t6_cout", 32'(cout), 32'd0);

    repeat (3) @(negedge clk);
    chkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
